// File: rtl/alu_rs.sv
`default_nettype none
// ============================================================================
// Module   : alu_rs
// Brief    : Integer ALU reservation station with dual-CDB operand snooping.
// Revision : 1.0
// ============================================================================
module alu_rs #(
  parameter int DEPTH  = 8,
  parameter int IDX_W  = 3,
  parameter int DATA_W = 32,
  parameter int OP_W   = 6,
  parameter int TAG_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              issue_valid,
  input  logic [OP_W-1:0]   issue_op,
  input  logic [DATA_W-1:0] issue_vj,
  input  logic [DATA_W-1:0] issue_vk,
  input  logic              issue_qj_wait,
  input  logic              issue_qk_wait,
  input  logic [TAG_W-1:0]  issue_qj,
  input  logic [TAG_W-1:0]  issue_qk,
  input  logic [DATA_W-1:0] issue_imm,
  input  logic [DATA_W-1:0] issue_pc,
  input  logic [TAG_W-1:0]  issue_dest,
  output logic              full,
  input  logic              cdb0_valid,
  input  logic [TAG_W-1:0]  cdb0_tag,
  input  logic [DATA_W-1:0] cdb0_data,
  input  logic              cdb1_valid,
  input  logic [TAG_W-1:0]  cdb1_tag,
  input  logic [DATA_W-1:0] cdb1_data,
  output logic [OP_W-1:0]   op_to_alu,
  output logic [DATA_W-1:0] v1_to_alu,
  output logic [DATA_W-1:0] v2_to_alu,
  output logic [DATA_W-1:0] imm_to_alu,
  output logic [DATA_W-1:0] pc_to_alu,
  output logic [TAG_W-1:0]  dest_to_rob,
  output logic              empty_to_alu
);

  localparam logic [IDX_W:0] c_DEPTH = (IDX_W+1)'(DEPTH);

  logic [DEPTH-1:0]  r_busy;
  logic [DEPTH-1:0]  r_wj;
  logic [DEPTH-1:0]  r_wk;
  logic [OP_W-1:0]   r_op   [DEPTH];
  logic [DATA_W-1:0] r_vj   [DEPTH];
  logic [DATA_W-1:0] r_vk   [DEPTH];
  logic [TAG_W-1:0]  r_qj   [DEPTH];
  logic [TAG_W-1:0]  r_qk   [DEPTH];
  logic [DATA_W-1:0] r_imm  [DEPTH];
  logic [DATA_W-1:0] r_pc   [DEPTH];
  logic [TAG_W-1:0]  r_dest [DEPTH];
  logic [IDX_W:0]    r_count;

  logic [OP_W-1:0]   r_op_out;
  logic [DATA_W-1:0] r_v1_out;
  logic [DATA_W-1:0] r_v2_out;
  logic [DATA_W-1:0] r_imm_out;
  logic [DATA_W-1:0] r_pc_out;
  logic [TAG_W-1:0]  r_dest_out;
  logic              r_empty;

  logic [IDX_W-1:0]  w_free_idx;
  logic [IDX_W-1:0]  w_disp_idx;
  logic              w_disp_any;
  logic              w_full;
  logic              w_accept;

  // Returns {still_pending, value}; cdb0 has priority over cdb1.
  function automatic logic [DATA_W:0] f_resolve(input logic pend,
                                                input logic [TAG_W-1:0] q,
                                                input logic [DATA_W-1:0] v);
    if (pend && cdb0_valid && (cdb0_tag == q))
      return {1'b0, cdb0_data};
    else if (pend && cdb1_valid && (cdb1_tag == q))
      return {1'b0, cdb1_data};
    else
      return {pend, v};
  endfunction

  assign w_full   = (r_count == c_DEPTH);
  assign w_accept = issue_valid && !w_full && !flush;

  always_comb begin
    w_free_idx = '0;
    w_disp_idx = '0;
    w_disp_any = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!r_busy[i])
        w_free_idx = IDX_W'(i);
      if (r_busy[i] && !r_wj[i] && !r_wk[i]) begin
        w_disp_idx = IDX_W'(i);
        w_disp_any = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_busy     <= '0;
      r_wj       <= '0;
      r_wk       <= '0;
      r_count    <= '0;
      r_empty    <= 1'b1;
      r_op_out   <= '0;
      r_v1_out   <= '0;
      r_v2_out   <= '0;
      r_imm_out  <= '0;
      r_pc_out   <= '0;
      r_dest_out <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_op[i]   <= '0;
        r_vj[i]   <= '0;
        r_vk[i]   <= '0;
        r_qj[i]   <= '0;
        r_qk[i]   <= '0;
        r_imm[i]  <= '0;
        r_pc[i]   <= '0;
        r_dest[i] <= '0;
      end
    end else if (flush) begin
      r_busy  <= '0;
      r_count <= '0;
      r_empty <= 1'b1;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (r_busy[i]) begin
          {r_wj[i], r_vj[i]} <= f_resolve(r_wj[i], r_qj[i], r_vj[i]);
          {r_wk[i], r_vk[i]} <= f_resolve(r_wk[i], r_qk[i], r_vk[i]);
        end
      end

      if (w_disp_any) begin
        r_busy[w_disp_idx] <= 1'b0;
        r_op_out           <= r_op[w_disp_idx];
        r_v1_out           <= r_vj[w_disp_idx];
        r_v2_out           <= r_vk[w_disp_idx];
        r_imm_out          <= r_imm[w_disp_idx];
        r_pc_out           <= r_pc[w_disp_idx];
        r_dest_out         <= r_dest[w_disp_idx];
        r_empty            <= 1'b0;
      end else begin
        r_empty <= 1'b1;
      end

      // The free slot was idle in registered state, so it never collides with snoop or dispatch.
      if (w_accept) begin
        r_busy[w_free_idx] <= 1'b1;
        r_op[w_free_idx]   <= issue_op;
        r_qj[w_free_idx]   <= issue_qj;
        r_qk[w_free_idx]   <= issue_qk;
        r_imm[w_free_idx]  <= issue_imm;
        r_pc[w_free_idx]   <= issue_pc;
        r_dest[w_free_idx] <= issue_dest;
        {r_wj[w_free_idx], r_vj[w_free_idx]} <= f_resolve(issue_qj_wait, issue_qj, issue_vj);
        {r_wk[w_free_idx], r_vk[w_free_idx]} <= f_resolve(issue_qk_wait, issue_qk, issue_vk);
      end

      case ({w_accept, w_disp_any})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign full         = w_full;
  assign op_to_alu    = r_op_out;
  assign v1_to_alu    = r_v1_out;
  assign v2_to_alu    = r_v2_out;
  assign imm_to_alu   = r_imm_out;
  assign pc_to_alu    = r_pc_out;
  assign dest_to_rob  = r_dest_out;
  assign empty_to_alu = r_empty;

endmodule
`default_nettype wire

// File: tb/tb_alu_rs.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_rs
// Brief    : Self-checking bench for alu_rs against a behavioural model.
// Revision : 1.0
// ============================================================================
module tb_alu_rs;

  logic        clk, rst, flush, issue_valid;
  logic [5:0]  issue_op;
  logic [31:0] issue_vj, issue_vk, issue_imm, issue_pc;
  logic        issue_qj_wait, issue_qk_wait;
  logic [3:0]  issue_qj, issue_qk, issue_dest;
  logic        full;
  logic        cdb0_valid, cdb1_valid;
  logic [3:0]  cdb0_tag, cdb1_tag;
  logic [31:0] cdb0_data, cdb1_data;
  logic [5:0]  op_to_alu;
  logic [31:0] v1_to_alu, v2_to_alu, imm_to_alu, pc_to_alu;
  logic [3:0]  dest_to_rob;
  logic        empty_to_alu;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 0;

  alu_rs dut (
    .clk(clk), .rst(rst), .flush(flush),
    .issue_valid(issue_valid), .issue_op(issue_op),
    .issue_vj(issue_vj), .issue_vk(issue_vk),
    .issue_qj_wait(issue_qj_wait), .issue_qk_wait(issue_qk_wait),
    .issue_qj(issue_qj), .issue_qk(issue_qk),
    .issue_imm(issue_imm), .issue_pc(issue_pc), .issue_dest(issue_dest),
    .full(full),
    .cdb0_valid(cdb0_valid), .cdb0_tag(cdb0_tag), .cdb0_data(cdb0_data),
    .cdb1_valid(cdb1_valid), .cdb1_tag(cdb1_tag), .cdb1_data(cdb1_data),
    .op_to_alu(op_to_alu), .v1_to_alu(v1_to_alu), .v2_to_alu(v2_to_alu),
    .imm_to_alu(imm_to_alu), .pc_to_alu(pc_to_alu),
    .dest_to_rob(dest_to_rob), .empty_to_alu(empty_to_alu)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    bit        busy;
    bit [5:0]  op;
    bit [31:0] vj, vk;
    bit [3:0]  qj, qk;
    bit        wj, wk;
    bit [31:0] imm, pc;
    bit [3:0]  dest;
  } ent_t;

  ent_t      m [8];
  bit        e_empty;
  bit [5:0]  e_op;
  bit [31:0] e_v1, e_v2, e_imm, e_pc;
  bit [3:0]  e_dest;

  function automatic bit [32:0] res(input bit p, input bit [3:0] q, input bit [31:0] v);
    if (p && cdb0_valid && cdb0_tag == q) return {1'b0, cdb0_data};
    if (p && cdb1_valid && cdb1_tag == q) return {1'b0, cdb1_data};
    return {p, v};
  endfunction

  function automatic int occupancy();
    int n = 0;
    for (int i = 0; i < 8; i++) if (m[i].busy) n++;
    return n;
  endfunction

  always @(posedge clk or negedge rst) begin : mdl
    int d, f;
    if (!rst) begin
      for (int i = 0; i < 8; i++) m[i] = '0;
      e_empty = 1; e_op = 0; e_v1 = 0; e_v2 = 0; e_imm = 0; e_pc = 0; e_dest = 0;
    end else if (flush) begin
      for (int i = 0; i < 8; i++) m[i].busy = 0;
      e_empty = 1;
    end else begin
      d = -1; f = -1;
      for (int i = 0; i < 8; i++) begin
        if (d < 0 && m[i].busy && !m[i].wj && !m[i].wk) d = i;
        if (f < 0 && !m[i].busy) f = i;
      end
      for (int i = 0; i < 8; i++)
        if (m[i].busy) begin
          {m[i].wj, m[i].vj} = res(m[i].wj, m[i].qj, m[i].vj);
          {m[i].wk, m[i].vk} = res(m[i].wk, m[i].qk, m[i].vk);
        end
      if (d >= 0) begin
        e_empty = 0; e_op = m[d].op; e_v1 = m[d].vj; e_v2 = m[d].vk;
        e_imm = m[d].imm; e_pc = m[d].pc; e_dest = m[d].dest;
        m[d].busy = 0;
      end else e_empty = 1;
      if (issue_valid && f >= 0 && !(f == d)) begin
        m[f].busy = 1; m[f].op = issue_op; m[f].qj = issue_qj; m[f].qk = issue_qk;
        m[f].imm = issue_imm; m[f].pc = issue_pc; m[f].dest = issue_dest;
        {m[f].wj, m[f].vj} = res(issue_qj_wait, issue_qj, issue_vj);
        {m[f].wk, m[f].vk} = res(issue_qk_wait, issue_qk, issue_vk);
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("full",  {31'b0, full},         {31'b0, occupancy() == 8});
      chk("empty", {31'b0, empty_to_alu}, {31'b0, e_empty});
      chk("op",    {26'b0, op_to_alu},    {26'b0, e_op});
      chk("v1",    v1_to_alu,             e_v1);
      chk("v2",    v2_to_alu,             e_v2);
      chk("imm",   imm_to_alu,            e_imm);
      chk("pc",    pc_to_alu,             e_pc);
      chk("dest",  {28'b0, dest_to_rob},  {28'b0, e_dest});
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle();
    flush = 0; issue_valid = 0; issue_op = 0; issue_vj = 0; issue_vk = 0;
    issue_qj_wait = 0; issue_qk_wait = 0; issue_qj = 0; issue_qk = 0;
    issue_imm = 0; issue_pc = 0; issue_dest = 0;
    cdb0_valid = 0; cdb0_tag = 0; cdb0_data = 0;
    cdb1_valid = 0; cdb1_tag = 0; cdb1_data = 0;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic issue(input bit [5:0] op, input bit [3:0] dest, input bit [31:0] vj,
                       input bit [31:0] vk, input bit wj, input bit [3:0] qj);
    issue_valid = 1; issue_op = op; issue_dest = dest; issue_vj = vj; issue_vk = vk;
    issue_qj_wait = wj; issue_qj = qj; issue_qk_wait = 0; issue_qk = 0;
    issue_imm = 32'h10 + 32'(dest); issue_pc = 32'h1000 + 32'(dest);
  endtask

  initial begin
    idle();
    rst = 0;
    repeat (2) step();
    rst = 1;
    cmp_en = 1;
    chk("rst_empty", {31'b0, empty_to_alu}, 32'd1);
    chk("rst_full",  {31'b0, full},         32'd0);
    chk("rst_v1",    v1_to_alu,             32'd0);

    // simple ready issue
    issue(6'd1, 4'd3, 32'd5, 32'd7, 0, 0);
    step(); idle();
    chk("t1_pre_empty", {31'b0, empty_to_alu}, 32'd1);
    step();
    chk("t1_empty", {31'b0, empty_to_alu}, 32'd0);
    chk("t1_v1",    v1_to_alu,             32'd5);
    chk("t1_v2",    v2_to_alu,             32'd7);
    chk("t1_dest",  {28'b0, dest_to_rob},  32'd3);
    step();
    chk("t1_after", {31'b0, empty_to_alu}, 32'd1);

    // wake through cdb1
    issue(6'd2, 4'd2, 32'd0, 32'd1, 1, 4'd9);
    step(); idle();
    for (int i = 0; i < 3; i++) begin
      chk("t2_wait", {31'b0, empty_to_alu}, 32'd1);
      step();
    end
    cdb1_valid = 1; cdb1_tag = 9; cdb1_data = 32'h100;
    step(); idle();
    chk("t2_nodisp", {31'b0, empty_to_alu}, 32'd1);
    step();
    chk("t2_empty", {31'b0, empty_to_alu}, 32'd0);
    chk("t2_v1",    v1_to_alu,             32'h100);
    chk("t2_dest",  {28'b0, dest_to_rob},  32'd2);

    // issue-time bypass with both CDBs matching
    issue(6'd3, 4'd5, 32'd0, 32'd2, 1, 4'd4);
    cdb0_valid = 1; cdb0_tag = 4; cdb0_data = 32'hA;
    cdb1_valid = 1; cdb1_tag = 4; cdb1_data = 32'hB;
    step(); idle();
    step();
    chk("t3_empty", {31'b0, empty_to_alu}, 32'd0);
    chk("t3_v1",    v1_to_alu,             32'hA);

    // fill, overflow, ordered drain
    step();
    for (int i = 0; i < 8; i++) begin
      issue(6'd4, 4'(i), 32'd0, 32'(i), 1, 4'd1);
      step();
    end
    chk("t4_full", {31'b0, full}, 32'd1);
    issue(6'd4, 4'd15, 32'd0, 32'd0, 0, 0);
    step(); idle();
    chk("t4_full_hold", {31'b0, full}, 32'd1);
    cdb0_valid = 1; cdb0_tag = 1; cdb0_data = 32'h55;
    step(); idle();
    for (int i = 0; i < 8; i++) begin
      step();
      chk("t4_empty", {31'b0, empty_to_alu}, 32'd0);
      chk("t4_order", {28'b0, dest_to_rob},  32'(i));
      if (i == 0) chk("t4_full_drop", {31'b0, full}, 32'd0);
    end
    step();
    chk("t4_drained", {31'b0, empty_to_alu}, 32'd1);

    // flush with a ready entry 2 and a concurrent issue
    issue(6'd5, 4'd0, 0, 0, 1, 4'd7); step();
    issue(6'd5, 4'd1, 0, 0, 1, 4'd7); step();
    issue(6'd5, 4'd2, 0, 0, 1, 4'd6); step();
    issue(6'd5, 4'd3, 0, 0, 1, 4'd7);
    cdb0_valid = 1; cdb0_tag = 6; cdb0_data = 32'h66;
    step(); idle();
    flush = 1;
    issue(6'd6, 4'd9, 32'd1, 32'd1, 0, 0);
    step(); idle();
    chk("t5_empty", {31'b0, empty_to_alu}, 32'd1);
    chk("t5_full",  {31'b0, full},         32'd0);
    chk("t5_hold",  {28'b0, dest_to_rob},  32'd7);
    step();
    chk("t5_nodrop", {31'b0, empty_to_alu}, 32'd1);

    // asynchronous reset while entry 0 is ready
    issue(6'd7, 4'd4, 32'h77, 32'd1, 0, 0);
    step(); idle();
    #2 rst = 0;
    #1;
    chk("t6_empty", {31'b0, empty_to_alu}, 32'd1);
    chk("t6_v1",    v1_to_alu,             32'd0);
    chk("t6_op",    {26'b0, op_to_alu},    32'd0);
    chk("t6_dest",  {28'b0, dest_to_rob},  32'd0);
    @(negedge clk);
    rst = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t6_quiet", {31'b0, empty_to_alu}, 32'd1);
    end

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      idle();
      issue_valid   = ($urandom_range(0, 99) < 60);
      issue_op      = 6'($urandom);
      issue_vj      = $urandom;
      issue_vk      = $urandom;
      issue_qj_wait = $urandom_range(0, 1) == 1;
      issue_qk_wait = $urandom_range(0, 2) == 0;
      issue_qj      = 4'($urandom_range(0, 5));
      issue_qk      = 4'($urandom_range(0, 5));
      issue_imm     = $urandom;
      issue_pc      = $urandom;
      issue_dest    = 4'($urandom);
      cdb0_valid    = ($urandom_range(0, 99) < 35);
      cdb0_tag      = 4'($urandom_range(0, 5));
      cdb0_data     = $urandom;
      cdb1_valid    = ($urandom_range(0, 99) < 35);
      cdb1_tag      = 4'($urandom_range(0, 5));
      cdb1_data     = $urandom;
      flush         = ($urandom_range(0, 99) < 2);
      step();
    end
    idle();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
